// File: rtl/mat_stream_loader_pkg.sv
// Shared defaults, state type and width helper for the matrix stream loader.
package mat_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int MATRIX_DIM_DEF  = 10;
    localparam int MATRIX_SIZE_DEF = MATRIX_DIM_DEF * MATRIX_DIM_DEF;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } mat_state_e;

    // Number of bits needed to hold every value in 0..max_val (at least one).
    function automatic int width_for(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mat_stream_loader_if.sv
// Element input stream and determinant result stream of the matrix loader.
interface mat_stream_loader_if
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_valid;
    logic                  res_ready;

    // master: the host feeding elements and consuming results
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  res_data,
        input  res_valid,
        output res_ready
    );

    // slave: the loader itself
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output res_data,
        output res_valid,
        input  res_ready
    );

endinterface

// File: rtl/mat_stream_loader_settle_timer.sv
// Counts edges spent in SETTLE; done is raised on the CYCLES-th counting edge.
module settle_timer
    import mat_pkg::*;
#(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    localparam int CNT_W = width_for(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i && (cnt_q != CNT_LAST)) begin
            // saturate at the terminal value so the counter can never wrap
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = count_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mat_stream_loader.sv
// Collects a row-major element stream into a packed matrix, waits for the external
// combinational determinant to settle, then presents the captured result.
module mat_stream_loader
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int MATRIX_DIM    = MATRIX_DIM_DEF,
    parameter int MATRIX_SIZE   = MATRIX_SIZE_DEF,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    mat_stream_loader_if.slave                bus,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0] mat,
    input  logic [DATA_WIDTH-1:0]             det_in,
    output logic                              busy
);

    localparam int IDX_W = width_for(MATRIX_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MATRIX_SIZE - 1);

    mat_state_e            state_q;
    mat_state_e            state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [DATA_WIDTH-1:0] res_data_d;
    logic                  res_valid_q;
    logic                  res_valid_d;

    logic wr_en;
    logic timer_load;
    logic timer_count;
    logic timer_done;

    settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (timer_load),
        .count_i (timer_count),
        .done_o  (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        wr_en       = 1'b0;
        timer_load  = 1'b0;
        timer_count = 1'b0;

        if (clear) begin
            // flush wins over everything; an element offered now is dropped
            state_d     = LOAD;
            idx_d       = '0;
            res_valid_d = 1'b0;
            timer_load  = 1'b1;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (bus.in_valid) begin
                        wr_en = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d      = '0;
                            timer_load = 1'b1;
                            state_d    = SETTLE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    timer_count = 1'b1;
                    if (timer_done) begin
                        res_data_d  = det_in;
                        res_valid_d = 1'b1;
                        state_d     = RESULT;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = LOAD;
                    end
                end
                default: begin
                    state_d     = LOAD;
                    idx_d       = '0;
                    res_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    // One register per element; slot k = row*MATRIX_DIM+col sits at mat[k*DATA_WIDTH +: DATA_WIDTH].
    genvar gi;
    genvar gj;
    for (gi = 0; gi < MATRIX_DIM; gi++) begin : g_row
        for (gj = 0; gj < MATRIX_DIM; gj++) begin : g_col
            localparam int SLOT = gi * MATRIX_DIM + gj;
            logic [DATA_WIDTH-1:0] slot_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else if (wr_en && (idx_q == IDX_W'(SLOT))) begin
                    slot_q <= bus.in_data;
                end
            end

            assign mat[SLOT*DATA_WIDTH +: DATA_WIDTH] = slot_q;
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign busy          = (state_q != LOAD) || (idx_q != '0);

endmodule

// File: doc/mat_stream_loader.md
MAT_STREAM_LOADER -- requirements
Module: mat_stream_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bit width of one matrix element and of the determinant.
REQ-002 SHALL have parameter MATRIX_DIM, default 10, matrix rows/columns.
REQ-003 SHALL have parameter MATRIX_SIZE, default 100, element count (MATRIX_DIM*MATRIX_DIM).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 4, cycles allowed for the downstream combinational determinant to settle; legal range >= 1.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-007 SHALL have port clear, input, 1, synchronous flush of the current job.
REQ-008 SHALL have port in_data, input, DATA_WIDTH, next element, row-major order.
REQ-009 SHALL have port in_valid, input, 1, in_data valid.
REQ-010 SHALL have port in_ready, output, 1, block accepts an element.
REQ-011 SHALL have port mat, output, MATRIX_SIZE*DATA_WIDTH, packed matrix to the determinant stage.
REQ-012 SHALL have port det_in, input, DATA_WIDTH, determinant returned by that stage.
REQ-013 SHALL have port res_data, output, DATA_WIDTH, captured determinant.
REQ-014 SHALL have port res_valid, output, 1, res_data valid.
REQ-015 SHALL have port res_ready, input, 1, consumer accepts res_data.
REQ-016 SHALL have port busy, output, 1, a job is in progress.

Function
REQ-017 Element k = row*MATRIX_DIM+col SHALL occupy mat[k*DATA_WIDTH +: DATA_WIDTH]; the first accepted element goes to bits [DATA_WIDTH-1:0].
REQ-018 States SHALL be LOAD, SETTLE and RESULT; in_ready = 1 only in LOAD.
REQ-019 In LOAD, each cycle with in_valid&in_ready SHALL write in_data to slot idx and increment idx; no write without a handshake.
REQ-020 The handshake with idx = MATRIX_SIZE-1 SHALL write the last slot, clear idx to 0, load the settle counter with 0 and move to SETTLE.
REQ-021 In SETTLE, det_in SHALL be sampled into res_data on the SETTLE_CYCLES-th rising edge after the last-element edge, with res_valid = 1 and the state moving to RESULT on that same edge; latency from last handshake to res_valid is exactly SETTLE_CYCLES cycles.
REQ-022 In RESULT, res_data and res_valid SHALL hold until res_valid&res_ready; on that edge res_valid goes to 0 and the state goes to LOAD.
REQ-023 mat SHALL change only on element writes; it is stable throughout SETTLE and RESULT, and old contents persist until overwritten.
REQ-024 busy SHALL be 1 when state != LOAD or idx != 0.
REQ-025 clear SHALL take priority over every other event: next state LOAD, idx 0, res_valid 0, and an element presented in the same cycle is dropped; mat and res_data are unchanged.
REQ-026 Arithmetic: idx SHALL be wide enough for MATRIX_SIZE-1 and never wrap; the settle counter is wide enough for SETTLE_CYCLES.

Reset
REQ-027 While rst_n = 0, SHALL force state LOAD, idx 0, settle counter 0, mat all-zero, res_data 0, res_valid 0, busy 0, in_ready 1 (after release).
REQ-028 Reset asserted mid-LOAD, mid-SETTLE or in RESULT SHALL abort the job with no res_valid pulse.

Structure
REQ-029 Package mat_pkg SHALL hold the DATA_WIDTH, MATRIX_DIM and MATRIX_SIZE defaults and the LOAD/SETTLE/RESULT state type.
REQ-030 Sub-module settle_timer (load, count, done flag) SHALL implement the settle counter; everything else stays flat.

Verification (bench instantiates matdet10 on mat -> det_in, SETTLE_CYCLES = 4)
REQ-031 SHALL cover identity matrix streamed with in_valid held high -> 100 handshakes, then res_valid exactly 4 cycles after the last handshake, with res_data = 0x01.
REQ-032 SHALL cover diagonal of 3s with in_valid toggled on alternate cycles -> res_data = 0xA9 (3^10 mod 256), mat unchanged while res_valid = 1.
REQ-033 SHALL cover res_ready held low for 5 cycles after res_valid -> res_data stable and in_ready = 0 throughout; on the accept edge res_valid drops and in_ready rises the next cycle.
REQ-034 SHALL cover clear pulsed after 37 elements with in_valid = 1 -> that element dropped and idx 0; a following full identity load gives 0x01.
REQ-035 SHALL cover rst_n pulsed low during SETTLE -> no res_valid, mat = 0, busy = 0, in_ready = 1.
REQ-036 SHALL cover back-to-back jobs: diagonal 2 then identity -> 0x00 then 0x01, with no element lost between jobs.
